// File: rtl/exec_stage_pkg.sv
// exec_stage_pkg: shared encodings, payload type and helpers for the execute stage
package exec_stage_pkg;
    localparam int XLEN = 32;
    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } funct3_e;
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            we;
    } payload_t;
    function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
        return r;
    endfunction
endpackage

// File: rtl/exec_stage_alu.sv
// alu_comb: combinational RV32I OP/OP-IMM datapath with a single shared right-shifter
module alu_comb
    import exec_stage_pkg::*;
(
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    input  logic            use_imm,
    input  logic [2:0]      funct3,
    input  logic            alt,
    output logic [XLEN-1:0] result
);
    logic [XLEN-1:0] b, sum, sh_in, sh_out;
    logic            sub, left, fill;
    // Operand select, add/sub, shift (SLL via bit reversal around the right-shifter) and result mux
    always_comb begin
        b      = use_imm ? imm : rs2;
        sub    = alt & ~use_imm;
        sum    = sub ? rs1 - b : rs1 + b;
        left   = funct3 == F3_SLL;
        fill   = (funct3 == F3_SR) & alt & rs1[XLEN-1];
        sh_in  = left ? bit_rev(rs1) : rs1;
        sh_out = XLEN'($signed({fill, sh_in}) >>> b[4:0]);
        result = '0;
        case (funct3)
            F3_ADD:  result = sum;
            F3_SLL:  result = bit_rev(sh_out);
            F3_SLT:  result = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(b)};
            F3_SLTU: result = {{(XLEN-1){1'b0}}, rs1 < b};
            F3_XOR:  result = rs1 ^ b;
            F3_SR:   result = sh_out;
            F3_OR:   result = rs1 | b;
            F3_AND:  result = rs1 & b;
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/exec_stage.sv
// exec_stage: execute stage with ALU, output register and skid register handshake
module exec_stage
    import exec_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_rs1,
    input  logic [WIDTH-1:0] in_rs2,
    input  logic [WIDTH-1:0] in_imm,
    input  logic             in_use_imm,
    input  logic [2:0]       in_funct3,
    input  logic             in_alt,
    input  logic [4:0]       in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [4:0]       out_rd,
    output logic             out_we
);
    state_e          state, state_d;
    payload_t        or_q, or_d, sr_q, sr_d, in_pl;
    logic [XLEN-1:0] alu_res;
    logic            accept, pop;

    alu_comb u_alu (
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .use_imm (in_use_imm),
        .funct3  (in_funct3),
        .alt     (in_alt),
        .result  (alu_res)
    );

    assign in_ready   = state != TWO;
    assign out_valid  = state != EMPTY;
    assign accept     = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign in_pl      = {alu_res, in_rd, in_rd != 5'd0};
    assign out_result = or_q.result;
    assign out_rd     = or_q.rd;
    assign out_we     = or_q.we;

    // Next state and buffer loads; flush overrides everything and drops both payloads
    always_comb begin
        state_d = state;
        or_d    = or_q;
        sr_d    = sr_q;
        if (flush) begin
            state_d = EMPTY;
            or_d    = '0;
            sr_d    = '0;
        end else begin
            case (state)
                EMPTY: begin
                    state_d = accept ? ONE : EMPTY;
                    or_d    = accept ? in_pl : or_q;
                end
                ONE: begin
                    state_d = accept ? (pop ? ONE : TWO) : (pop ? EMPTY : ONE);
                    or_d    = (accept & pop) ? in_pl : or_q;
                    sr_d    = (accept & ~pop) ? in_pl : sr_q;
                end
                TWO: begin
                    state_d = pop ? ONE : TWO;
                    or_d    = pop ? sr_q : or_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and payload registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            or_q  <= '0;
            sr_q  <= '0;
        end else begin
            state <= state_d;
            or_q  <= or_d;
            sr_q  <= sr_d;
        end
    end
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: scoreboard bench for exec_stage with directed vectors
module tb_exec_stage;
    typedef struct packed {
        logic [31:0] r;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    logic        clk, rst_n, flush, in_valid, in_ready, in_use_imm, in_alt;
    logic        out_valid, out_ready, out_we;
    logic [31:0] in_rs1, in_rs2, in_imm, out_result;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd, out_rd;
    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;

    exec_stage #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
        .in_funct3  (in_funct3),
        .in_alt     (in_alt),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_we     (out_we)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every popped output against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result %h rd %0d with nothing expected", out_result, out_rd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_result", out_result, e.r);
                chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
                chk("out_we", {31'd0, out_we}, {31'd0, e.we});
            end
        end
    end

    task automatic drive(input logic [31:0] rs1, rs2, imm, input logic ui, input logic [2:0] f3,
                         input logic alt, input logic [4:0] rd);
        in_valid   = 1;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_imm     = imm;
        in_use_imm = ui;
        in_funct3  = f3;
        in_alt     = alt;
        in_rd      = rd;
    endtask

    task automatic wait_accept(input logic [31:0] er, input logic [4:0] rd);
        bit done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{er, rd, rd != 5'd0});
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no in_ready expected accept of rd %0d", rd);
        end
    endtask

    task automatic send(input logic [31:0] rs1, rs2, imm, input logic ui, input logic [2:0] f3,
                        input logic alt, input logic [4:0] rd, input logic [31:0] er);
        drive(rs1, rs2, imm, ui, f3, alt, rd);
        wait_accept(er, rd);
    endtask

    task automatic drain();
        bit done = 0;
        in_valid = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            #1;
            done = sb.size() == 0;
        end
        @(posedge clk);
        #1;
        chk("drain_pending", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1);
    end

    initial begin
        rst_n = 0; flush = 0; out_ready = 1;
        drive(0, 0, 0, 0, 3'b000, 0, 0);
        in_valid = 0;
        #2;
        chk("reset_out_valid", {31'd0, out_valid}, 0);
        chk("reset_in_ready", {31'd0, in_ready}, 1);
        chk("reset_out_result", out_result, 0);
        chk("reset_out_we", {31'd0, out_we}, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        // Directed ALU vectors, out_ready held high
        send(32'd5, 32'd7, 0, 0, 3'b000, 1, 3, 32'hFFFFFFFE);
        send(32'h80000000, 32'h21, 0, 0, 3'b101, 1, 4, 32'hC0000000);
        send(32'h80000000, 0, 32'h21, 1, 3'b101, 0, 5, 32'h40000000);
        send(32'd1, 0, 32'd31, 1, 3'b001, 0, 6, 32'h80000000);
        send(32'h80000001, 32'd4, 0, 0, 3'b001, 1, 7, 32'h00000010);
        send(32'hFFFFFFFF, 32'd1, 0, 0, 3'b010, 0, 8, 32'd1);
        send(32'hFFFFFFFF, 32'd1, 0, 0, 3'b011, 0, 0, 32'd0);
        send(32'd1, 32'hFFFFFFFF, 0, 0, 3'b010, 0, 15, 32'd0);
        send(32'd1, 32'hFFFFFFFF, 0, 0, 3'b011, 0, 16, 32'd1);
        send(32'd10, 0, 32'hFFFFFFFF, 1, 3'b000, 1, 9, 32'd9);
        send(32'hFFFFFFFF, 32'd2, 0, 0, 3'b000, 0, 10, 32'd1);
        send(32'h0000F0F0, 32'h0000FF00, 0, 0, 3'b100, 1, 11, 32'h00000FF0);
        send(32'h0000F0F0, 0, 32'h0000FF00, 1, 3'b110, 0, 12, 32'h0000FFF0);
        send(32'h0000F0F0, 32'h0000FF00, 0, 0, 3'b111, 1, 13, 32'h0000F000);
        send(32'h40000000, 32'd1, 0, 0, 3'b101, 1, 14, 32'h20000000);
        drain();
        // Back-pressure: two accepted, third stalls until out_ready rises
        out_ready = 0;
        send(32'd1, 32'd1, 0, 0, 3'b000, 0, 17, 32'd2);
        send(32'd3, 32'd5, 0, 0, 3'b100, 0, 18, 32'd6);
        drive(32'd7, 32'd3, 0, 0, 3'b111, 0, 19);
        @(negedge clk);
        chk("bp_in_ready", {31'd0, in_ready}, 0);
        chk("bp_out_valid", {31'd0, out_valid}, 1);
        chk("bp_hold_result", out_result, 32'd2);
        @(posedge clk);
        #1;
        out_ready = 1;
        wait_accept(32'd3, 19);
        drain();
        // Flush while full with a valid input present
        out_ready = 0;
        send(32'd2, 32'd2, 0, 0, 3'b000, 0, 20, 32'd4);
        send(32'd2, 32'd3, 0, 0, 3'b000, 0, 21, 32'd5);
        drive(32'd9, 32'd9, 0, 0, 3'b000, 0, 22);
        flush = 1;
        @(posedge clk);
        #1;
        flush = 0;
        in_valid = 0;
        sb.delete();
        chk("flush_out_valid", {31'd0, out_valid}, 0);
        chk("flush_in_ready", {31'd0, in_ready}, 1);
        out_ready = 1;
        send(32'd6, 32'd1, 0, 0, 3'b110, 0, 23, 32'd7);
        drain();
        // Asynchronous reset while full with a valid input present
        out_ready = 0;
        send(32'd2, 32'd2, 0, 0, 3'b000, 0, 24, 32'd4);
        send(32'd2, 32'd3, 0, 0, 3'b000, 0, 25, 32'd5);
        drive(32'd9, 32'd9, 0, 0, 3'b000, 0, 26);
        #2;
        rst_n = 0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_out_result", out_result, 0);
        sb.delete();
        in_valid = 0;
        #3;
        rst_n = 1;
        @(posedge clk);
        #1;
        out_ready = 1;
        send(32'd8, 32'd2, 0, 0, 3'b101, 0, 27, 32'd2);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width; only 32 is supported (shift amount is 5 bits).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active low
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept
- in_rs1  in  WIDTH  operand A
- in_rs2  in  WIDTH  register operand B
- in_imm  in  WIDTH  sign-extended immediate
- in_use_imm  in  1  B = in_imm when 1, else in_rs2
- in_funct3  in  3  RV32I OP/OP-IMM funct3
- in_alt  in  1  funct7[5] (SUB / SRA select)
- in_rd  in  5  destination register
- out_valid  out  1  result present
- out_ready  in  1  writeback can accept
- out_result  out  WIDTH  ALU result
- out_rd  out  5  destination register
- out_we  out  1  write enable, 1 iff out_rd != 0

Function
REQ-003 Result by funct3: 000 ADD, or SUB when in_alt=1 and in_use_imm=0; 001 SLL; 010 SLT (signed, result 0/1); 011 SLTU (result 0/1); 100 XOR; 101 SRL, or SRA when in_alt=1; 110 OR; 111 AND.
REQ-004 in_alt SHALL be ignored for funct3 other than 000 and 101; ADDI with in_alt=1 SHALL add.
REQ-005 Shift amount SHALL be B[4:0]; upper bits of B are ignored; add and subtract wrap modulo 2^WIDTH.
REQ-006 Left and right shifts SHALL share one right-shifter, with bit reversal of the operand and result for SLL; SRA fills with A[31] and SRL fills with zero.
REQ-007 Result SHALL be computed combinationally from the inputs and registered on acceptance; latency is exactly 1 cycle from the accept edge to out_valid.
REQ-008 Handshake: accept = in_valid & in_ready; pop = out_valid & out_ready; a payload is held stable while out_valid=1 and out_ready=0.
REQ-009 Buffering is an output register (OR) plus a skid register (SR), with states EMPTY, ONE and TWO.
REQ-010 in_ready SHALL equal (state != TWO), decoded from registered state only, with no combinational path from out_ready.
REQ-011 State transitions:
- EMPTY: on accept, go to ONE.
- ONE: on accept & pop, stay in ONE with OR reloaded; on accept & !pop, go to TWO with SR loaded; on pop only, go to EMPTY.
- TWO: on pop, go to ONE with OR <= SR.
REQ-012 Payloads SHALL be delivered in acceptance order, with no loss or duplication.
REQ-013 flush=1 SHALL force EMPTY at the next edge, discard OR and SR, and ignore any accept in the same cycle.
REQ-014 out_valid SHALL equal (state != EMPTY); out_result, out_rd and out_we SHALL be driven from OR.

Reset
REQ-015 On rst_n=0, asynchronously: state=EMPTY, out_valid=0, in_ready=1, and OR/SR contents cleared to 0.
REQ-016 Reset asserted mid-transfer SHALL discard all held payloads; after rst_n rises, the first accept SHALL behave as from EMPTY.

Structure
REQ-017 A shared package SHALL hold the funct3 encodings (F3_ADD … F3_AND), the XLEN=32 constant and a payload struct {result, rd, we}.
REQ-018 The ALU datapath SHALL be the single sub-module alu_comb (combinational, containing the bit-reversed shift); exec_stage owns only the handshake and registers.

Verification
REQ-019 A bench SHALL cover these directed scenarios:
- SUB: rs1=5, rs2=7, funct3=000, alt=1, use_imm=0, rd=3 -> next cycle out_result=0xFFFFFFFE, out_rd=3, out_we=1.
- Shifts: rs1=0x80000000, B=0x21 (shamt 1); funct3=101 alt=1 -> 0xC0000000; alt=0 -> 0x40000000; funct3=001 with rs1=1, B=31 -> 0x80000000.
- Back-pressure: out_ready=0 while 3 back-to-back valids -> two accepted, in_ready=0 on the third; raising out_ready delivers both in order, then the third is accepted.
- Compare and rd=0: SLT with rs1=0xFFFFFFFF, rs2=1 -> 1; SLTU with the same operands -> 0; rd=0 -> out_we=0.
- Flush/reset: state TWO plus flush with in_valid=1 -> next cycle out_valid=0, in_ready=1; repeat with rst_n pulsed low -> identical outcome, asynchronously.
